// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory responder:
//               FSM state encoding, LOAD/STORE encoding, word width and a
//               byte-address to word-index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int WORD_W = 32;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // Byte address to word index; the two low bits select a byte in the word.
    function automatic logic [29:0] word_index(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Single-port word-indexed storage. Synchronous write,
//               combinational read of the addressed word. Contents are not
//               initialised and are never cleared by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [MEM_WORDS];

    // Write port: one word per cycle when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : LOAD/STORE responder with fixed access latency. One request
//               outstanding at a time; every request gets exactly one
//               response, held until the processor accepts it.
//               Optional macro DMEM_ALIGN_CHECK_EN: when defined, a
//               misaligned byte address faults instead of being truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int         AW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

`ifdef DMEM_ALIGN_CHECK_EN
    localparam logic ALIGN_CHK = 1'b1;
`else
    localparam logic ALIGN_CHK = 1'b0;
`endif

    dmem_state_e       state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] rdata_q;
    logic              err_q;

    logic              accept;
    logic              access;
    logic              cur_we;
    logic [31:0]       cur_addr;
    logic [WORD_W-1:0] cur_wdata;
    logic [29:0]       cur_idx;
    logic              out_of_range;
    logic              misaligned;
    logic              fault;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    assign req_ready = rst && (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    assign accept = req_valid && req_ready;

    // With LATENCY=1 the access happens on the acceptance edge itself, so the
    // live request inputs feed the array; otherwise the latched copy does.
    assign access = ((state == ST_IDLE) && accept && (LATENCY == 1)) ||
                    ((state == ST_WAIT) && (cnt == 4'd1));

    assign cur_we    = (state == ST_IDLE) ? req_we    : we_q;
    assign cur_addr  = (state == ST_IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state == ST_IDLE) ? req_wdata : wdata_q;
    assign cur_idx   = word_index(cur_addr);

    assign out_of_range = ({2'b00, cur_idx} >= 32'(MEM_WORDS));
    assign misaligned   = (cur_addr[1:0] != 2'b00);
    assign fault        = out_of_range || (ALIGN_CHK && misaligned);
    assign mem_we       = access && (cur_we == OP_STORE) && !fault;

    dmem_array #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (cur_idx[AW-1:0]),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    // Request/response sequencing and request latching.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= LAT_M1;
                        state   <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Response payload is captured only at the access edge, so it stays
    // stable for the whole time the response is waiting to be taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (access) begin
            err_q   <= fault;
            rdata_q <= (!fault && (cur_we == OP_LOAD)) ? mem_rdata : '0;
        end
    end

endmodule
`default_nettype wire
